gerador_jogadas_param: RTL
==========================

# gerador_jogadas_param

Parametrised move-coordinate generator for the chess lab datapath. It keeps a free-running board scan pointer, like the original `gerador_jogadas`, and adds the following:
- Configurable board size.
- A pseudo-random start mode driven by an LFSR.
- Skipping of squares flagged as unavailable.
- A valid/ack handshake toward the game controller.
- Reporting when no free square exists.

## Interface
- `BOARD`, 8, squares per side; legal range 2..15, and `BOARD <= 2^COORD_W - 1`.
- `COORD_W`, 4, width of the coordinate outputs.
- `LFSR_SEED`, 16'hACE1, reset value of the LFSR; a value of 0 is replaced by 16'h0001.

Ports:
- `clock`  in  1  single clock; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `novaJogada`  in  1  move request; sampled only in IDLE.
- `modo`  in  1  start mode, sampled with the request: 0 = sequential, 1 = random.
- `ocupado`  in  `BOARD*BOARD`  square-unavailable mask; bit `(linha-1)*BOARD + (coluna-1)`; 1 = skip.
- `ack`  in  1  consumer accepts the delivered move.
- `coluna`  out  `COORD_W`  delivered column, 1-based.
- `linha`  out  `COORD_W`  delivered row, 1-based.
- `valida`  out  1  `coluna`/`linha` hold a move not yet acknowledged.
- `busy`  out  1  high in SEARCH and ENTREGA.
- `sem_casa`  out  1  one-cycle pulse: the search found no free square.
- `contagem`  out  8  count of acknowledged moves; wraps from 255 to 0.

## Operation
Scan pointer (`sl`, `sc`):
- Advances on every edge in every state.
- `sl` increments; at `sl == BOARD` it wraps to 1 and `sc` increments.
- At `sc == BOARD`, `sc` also wraps to 1.

LFSR:
- 16-bit Fibonacci LFSR, taps 16/14/13/11, steps on every edge.

States:
- **IDLE**
  - On `novaJogada == 1`: snapshot `ocupado`, clear step counter, go to SEARCH.
  - Search pointer start value: `modo == 0` loads the current (`sl`, `sc`) value, i.e. the value before this edge. `modo == 1` loads row `(lfsr[7:0] % BOARD) + 1` and column `(lfsr[15:8] % BOARD) + 1`.
  - `ack` is ignored.
- **SEARCH**
  - Each edge tests the snapshot bit at the search pointer.
  - If the square is free: latch the search pointer into `linha`/`coluna`, set `valida`, go to ENTREGA.
  - Otherwise: advance the search pointer in the same order and with the same wrap as the scan pointer, and increment the step counter.
  - If the tested square is occupied and the step counter equals `BOARD*BOARD-1`: pulse `sem_casa`, go to IDLE, leave `linha`/`coluna`/`valida` unchanged.
- **ENTREGA**
  - `valida` and the coordinates are held stable.
  - On `ack == 1`: clear `valida`, increment `contagem`, go to IDLE.

Boundary rules:
- `novaJogada` outside IDLE is dropped, not queued. This includes `novaJogada` arriving in the same cycle as `ack`.
- `ocupado` changes during SEARCH/ENTREGA have no effect because the snapshot is used.
- `reset` low at any time, including mid-search, aborts immediately and restores all reset values.
- Reset values:
  - `coluna` = 1, `linha` = 1.
  - `valida`, `busy`, `sem_casa` = 0; `contagem` = 0.
  - Scan pointer = (1,1); LFSR = seed; state = IDLE.

## Timing
- Request sampled at edge E0. The start square is tested at E1; if free, `valida` is 1 after E1. Best-case latency is 2 edges.
- In the worst found case, the last square is found at edge E(`BOARD*BOARD`).
- No free square: `sem_casa` is high for exactly the cycle after edge E(`BOARD*BOARD`), and `busy` drops at that same edge.
- `ack` sampled at edge Ea: `valida` and `busy` are 0 after Ea; `contagem` is updated after Ea; a new request is accepted at Ea+1 at the earliest.
- `busy` is 1 from after E0 until the SEARCH exit or ENTREGA exit.

## Test plan
- **Sequential start from reset:** release `reset`, `ocupado` = 0, `modo` = 0, `novaJogada` = 1 sampled at the 4th edge after release. Required: `valida` after the next edge, with `linha` = 4, `coluna` = 1.
- **Skip and wrap:** `BOARD` = 8, start at (8,8), mask blocks (8,8) and (1,1). Required: delivered square is `linha` = 2, `coluna` = 1, 3 edges after the request.
- **Board full:** `ocupado` all ones. Required: `sem_casa` pulses exactly once, 64 edges after the request edge, and `valida` stays 0.
- **Handshake:** hold `ack` = 0 for 10 cycles. Required: outputs stay stable and `valida` = 1 throughout. Assert `ack` together with `novaJogada`. Required: `contagem` increments by 1, the request is dropped, and the state is IDLE.
- **Random mode:** with `LFSR_SEED` default, request with `modo` = 1 on the first edge after release. Required: the start square matches a reference-model LFSR, and two runs from the same reset give identical sequences.
- **Mid-search reset:** assert `reset` = 0 during SEARCH. Required: the next cycle shows all reset values, and no `valida` or `sem_casa` is seen.

Source files
------------

// File: rtl/gerador_jogadas_param.sv
// Parametrised move-coordinate generator: free-running board scan, LFSR random start,
// occupied-square skipping, valid/ack delivery and "no free square" reporting.
module gerador_jogadas_param #(
  parameter int          BOARD     = 8,
  parameter int          COORD_W   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     novaJogada,
  input  logic                     modo,
  input  logic [BOARD*BOARD-1:0]   ocupado,
  input  logic                     ack,
  output logic [COORD_W-1:0]       coluna,
  output logic [COORD_W-1:0]       linha,
  output logic                     valida,
  output logic                     busy,
  output logic                     sem_casa,
  output logic [7:0]               contagem
);

  localparam int                 NSQ       = BOARD * BOARD;
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
  localparam logic [COORD_W-1:0] LAST      = COORD_W'(BOARD);
  localparam logic [7:0]         LAST_STEP = 8'(NSQ - 1);
  localparam logic [15:0]        SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, SEARCH, ENTREGA} state_t;

  state_t             state;
  logic [COORD_W-1:0] sl, sc, srow, scol;
  logic [COORD_W-1:0] sl_nx, sc_nx, srow_nx, scol_nx;
  logic [COORD_W-1:0] rnd_row, rnd_col;
  logic [15:0]        lfsr;
  logic [NSQ-1:0]     snap;
  logic [7:0]         stepc;
  logic [31:0]        idx;
  logic               occ;

  always_comb begin
    sl_nx   = (sl == LAST) ? ONE : sl + ONE;
    sc_nx   = (sl == LAST) ? ((sc == LAST) ? ONE : sc + ONE) : sc;
    // The search pointer walks in the same row-fastest order as the scan pointer.
    srow_nx = (srow == LAST) ? ONE : srow + ONE;
    scol_nx = (srow == LAST) ? ((scol == LAST) ? ONE : scol + ONE) : scol;
    rnd_row = COORD_W'(({24'd0, lfsr[7:0]}  % 32'(BOARD)) + 32'd1);
    rnd_col = COORD_W'(({24'd0, lfsr[15:8]} % 32'(BOARD)) + 32'd1);
    idx     = (32'(srow) - 32'd1) * 32'(BOARD) + 32'(scol) - 32'd1;
    occ     = 1'b0;
    for (int unsigned i = 0; i < NSQ; i++) begin
      if (i == idx) occ = snap[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      sl       <= ONE;
      sc       <= ONE;
      srow     <= ONE;
      scol     <= ONE;
      lfsr     <= SEED;
      snap     <= '0;
      stepc    <= '0;
      coluna   <= ONE;
      linha    <= ONE;
      valida   <= 1'b0;
      busy     <= 1'b0;
      sem_casa <= 1'b0;
      contagem <= '0;
    end else begin
      sl       <= sl_nx;
      sc       <= sc_nx;
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      sem_casa <= 1'b0;
      case (state)
        IDLE: begin
          if (novaJogada) begin
            snap  <= ocupado;
            stepc <= '0;
            srow  <= modo ? rnd_row : sl;
            scol  <= modo ? rnd_col : sc;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (!occ) begin
            linha  <= srow;
            coluna <= scol;
            valida <= 1'b1;
            state  <= ENTREGA;
          end else if (stepc == LAST_STEP) begin
            sem_casa <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            srow  <= srow_nx;
            scol  <= scol_nx;
            stepc <= stepc + 8'd1;
          end
        end
        ENTREGA: begin
          if (ack) begin
            valida   <= 1'b0;
            busy     <= 1'b0;
            contagem <= contagem + 8'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
